// File: rtl/perf_sampler.sv
// Periodic requester for a perf_counters instance. It captures each returned count,
// accumulates the counts with saturation, and presents the latest sample on a valid/ready port.
module perf_sampler #(
    parameter int CNT_W = 4,
    parameter int ACC_W = 16,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [PER_W-1:0] period_i,
    input  logic             clear_i,
    output logic             sw_req_o,
    input  logic [CNT_W-1:0] p_count_i,
    output logic [CNT_W-1:0] sample_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             sat_o,
    output logic             ovr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_timer;
    logic             r_req;

    logic [CNT_W-1:0] r_sample;
    logic             r_valid;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic             r_ovr;

    logic [PER_W-1:0] w_start_per;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_sum;
    logic             w_xfer;

    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] base,
                                               input logic [CNT_W-1:0] cnt);
        return {1'b0, base} + {{(ACC_W + 1 - CNT_W){1'b0}}, cnt};
    endfunction

    function automatic logic [ACC_W-1:0] acc_sat(input logic [ACC_W:0] sum);
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    assign w_start_per = (period_i == '0) ? PER_ONE : period_i;

    // The request for each cycle is decided one edge early, so sw_req_o
    // comes straight from a flop and no input reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_period <= PER_ONE;
            r_timer  <= '0;
            r_req    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req <= 1'b0;
                    if (start_i) begin
                        r_state  <= S_RUN;
                        r_period <= w_start_per;
                        r_timer  <= w_start_per - PER_ONE;
                        r_req    <= (w_start_per == PER_ONE);
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
                        r_timer <= '0;
                        if (r_req) begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= S_DRAIN;
                            r_req   <= 1'b1;
                        end
                    end else if (r_req) begin
                        r_timer <= r_period - PER_ONE;
                        r_req   <= (r_period == PER_ONE);
                    end else begin
                        r_timer <= r_timer - PER_ONE;
                        r_req   <= (r_timer == PER_ONE);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes effect before the add, so a coincident capture seeds the sum.
    assign w_base = clear_i ? '0 : r_acc;
    assign w_sum  = acc_add(w_base, p_count_i);
    assign w_xfer = r_valid & ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (clear_i) begin
                r_acc <= '0;
                r_sat <= 1'b0;
                r_ovr <= 1'b0;
            end
            if (r_req) begin
                r_acc    <= acc_sat(w_sum);
                r_sample <= p_count_i;
                r_valid  <= 1'b1;
                if (w_sum[ACC_W]) begin
                    r_sat <= 1'b1;
                end
                if (r_valid && !ready_i) begin
                    r_ovr <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sw_req_o = r_req;
    assign sample_o = r_sample;
    assign valid_o  = r_valid;
    assign acc_o    = r_acc;
    assign sat_o    = r_sat;
    assign ovr_o    = r_ovr;

endmodule

// File: tb/tb_perf_sampler.sv
// Directed bench for perf_sampler: default-width instance plus a 5-bit accumulator instance for saturation.
module tb_perf_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        stop_i;
    logic [7:0]  period_i;
    logic        clear_i;
    logic [3:0]  p_count_i;
    logic        ready_i;

    logic        sw_req_o;
    logic [3:0]  sample_o;
    logic        valid_o;
    logic [15:0] acc_o;
    logic        sat_o;
    logic        ovr_o;

    logic        s_req;
    logic [3:0]  s_sample;
    logic        s_valid;
    logic [4:0]  s_acc;
    logic        s_sat;
    logic        s_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    perf_sampler #(.CNT_W(4), .ACC_W(16), .PER_W(8)) u_dut (
        .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
        .period_i(period_i), .clear_i(clear_i), .sw_req_o(sw_req_o),
        .p_count_i(p_count_i), .sample_o(sample_o), .valid_o(valid_o),
        .ready_i(ready_i), .acc_o(acc_o), .sat_o(sat_o), .ovr_o(ovr_o)
    );

    perf_sampler #(.CNT_W(4), .ACC_W(5), .PER_W(8)) u_sat (
        .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
        .period_i(period_i), .clear_i(clear_i), .sw_req_o(s_req),
        .p_count_i(p_count_i), .sample_o(s_sample), .valid_o(s_valid),
        .ready_i(ready_i), .acc_o(s_acc), .sat_o(s_sat), .ovr_o(s_ovr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req"},    32'(sw_req_o), 32'd0);
        check_eq({tag, "_valid"},  32'(valid_o),  32'd0);
        check_eq({tag, "_sample"}, 32'(sample_o), 32'd0);
        check_eq({tag, "_acc"},    32'(acc_o),    32'd0);
        check_eq({tag, "_sat"},    32'(sat_o),    32'd0);
        check_eq({tag, "_ovr"},    32'(ovr_o),    32'd0);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; period_i = 8'd0;
        clear_i = 1'b0; p_count_i = 4'd0; ready_i = 1'b0;
        step(); step();
        reset = 1'b0;
        check_reset_state("rst");
        check_eq("rst_sat_acc", 32'(s_acc), 32'd0);

        // Basic period: P=3, 2 events per interval
        start_i = 1'b1; period_i = 8'd3; p_count_i = 4'd2; ready_i = 1'b1;
        step(); start_i = 1'b0;
        check_eq("bp_req_c1", 32'(sw_req_o), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check_eq("bp_req_mid", 32'(sw_req_o), 32'd0);
            step();
            check_eq("bp_req_hit", 32'(sw_req_o), 32'd1);
            step();
            check_eq("bp_req_after", 32'(sw_req_o), 32'd0);
            check_eq("bp_sample", 32'(sample_o), 32'd2);
            check_eq("bp_valid", 32'(valid_o), 32'd1);
            check_eq("bp_acc", 32'(acc_o), 32'(2 * k));
        end

        // Stop on a request cycle: no extra request
        step(); check_eq("sr_req_c11", 32'(sw_req_o), 32'd0);
        step(); check_eq("sr_req_c12", 32'(sw_req_o), 32'd1);
        stop_i = 1'b1;
        step(); stop_i = 1'b0;
        check_eq("sr_req_c13", 32'(sw_req_o), 32'd0);
        check_eq("sr_acc", 32'(acc_o), 32'd8);
        step(); step();
        check_eq("sr_req_c15", 32'(sw_req_o), 32'd0);
        step(); step();
        check_eq("sr_req_c17", 32'(sw_req_o), 32'd0);

        // Stop and flush: P=5, stop 2 cycles after a request
        start_i = 1'b1; period_i = 8'd5; p_count_i = 4'd1;
        step(); start_i = 1'b0;
        step(); step(); step();
        check_eq("fl_req_s4", 32'(sw_req_o), 32'd0);
        step(); check_eq("fl_req_s5", 32'(sw_req_o), 32'd1);
        step(); check_eq("fl_acc_s6", 32'(acc_o), 32'd9);
        step(); stop_i = 1'b1;
        step(); stop_i = 1'b0;
        check_eq("fl_drain_req", 32'(sw_req_o), 32'd1);
        step();
        check_eq("fl_req_s9", 32'(sw_req_o), 32'd0);
        check_eq("fl_sample", 32'(sample_o), 32'd1);
        check_eq("fl_acc", 32'(acc_o), 32'd10);
        step(); step(); step(); step();
        check_eq("fl_idle", 32'(sw_req_o), 32'd0);

        // Restart; a start_i during RUN must not reload the period
        start_i = 1'b1; period_i = 8'd5;
        step(); start_i = 1'b0;
        step(); start_i = 1'b1; period_i = 8'd1;
        step(); start_i = 1'b0; period_i = 8'd5;
        check_eq("rs_ign_start", 32'(sw_req_o), 32'd0);
        step(); check_eq("rs_req_t4", 32'(sw_req_o), 32'd0);
        step(); check_eq("rs_req_t5", 32'(sw_req_o), 32'd1);
        stop_i = 1'b1;
        step(); stop_i = 1'b0;
        check_eq("rs_acc", 32'(acc_o), 32'd11);
        check_eq("rs_req_off", 32'(sw_req_o), 32'd0);

        // Period zero behaves as P=1
        clear_i = 1'b1;
        step(); clear_i = 1'b0;
        check_eq("pz_clr_acc", 32'(acc_o), 32'd0);
        start_i = 1'b1; period_i = 8'd0; p_count_i = 4'd1;
        step(); start_i = 1'b0;
        check_eq("pz_req_c1", 32'(sw_req_o), 32'd1);
        step();
        check_eq("pz_req_c2", 32'(sw_req_o), 32'd1);
        check_eq("pz_acc_c2", 32'(acc_o), 32'd1);
        check_eq("pz_sample", 32'(sample_o), 32'd1);
        step();
        check_eq("pz_acc_c3", 32'(acc_o), 32'd2);
        stop_i = 1'b1;
        step(); stop_i = 1'b0;
        check_eq("pz_acc_c4", 32'(acc_o), 32'd3);
        check_eq("pz_req_c4", 32'(sw_req_o), 32'd0);
        step();
        check_eq("pz_acc_c5", 32'(acc_o), 32'd3);
        check_eq("pz_valid_drop", 32'(valid_o), 32'd0);

        // Overrun: P=2, consumer stalled across captures of 3 then 5
        ready_i = 1'b0; clear_i = 1'b1;
        step(); clear_i = 1'b0;
        check_eq("ov_clr_ovr", 32'(ovr_o), 32'd0);
        start_i = 1'b1; period_i = 8'd2; p_count_i = 4'd3;
        step(); start_i = 1'b0;
        check_eq("ov_req_c1", 32'(sw_req_o), 32'd0);
        step(); check_eq("ov_req_c2", 32'(sw_req_o), 32'd1);
        step();
        check_eq("ov_valid_c3", 32'(valid_o), 32'd1);
        check_eq("ov_sample_c3", 32'(sample_o), 32'd3);
        check_eq("ov_ovr_c3", 32'(ovr_o), 32'd0);
        p_count_i = 4'd5;
        step(); check_eq("ov_req_c4", 32'(sw_req_o), 32'd1);
        step();
        check_eq("ov_sample_c5", 32'(sample_o), 32'd5);
        check_eq("ov_ovr_c5", 32'(ovr_o), 32'd1);
        check_eq("ov_valid_c5", 32'(valid_o), 32'd1);
        step(); ready_i = 1'b1; p_count_i = 4'd7;
        check_eq("ov_req_c6", 32'(sw_req_o), 32'd1);
        step();
        check_eq("ov_valid_c7", 32'(valid_o), 32'd1);
        check_eq("ov_ovr_c7", 32'(ovr_o), 32'd1);
        check_eq("ov_sample_c7", 32'(sample_o), 32'd7);
        step();
        check_eq("ov_valid_c8", 32'(valid_o), 32'd0);
        check_eq("ov_acc_c8", 32'(acc_o), 32'd15);
        stop_i = 1'b1;
        step(); stop_i = 1'b0;

        // Saturation on the 5-bit accumulator, then clear with a coincident sample
        clear_i = 1'b1;
        step(); clear_i = 1'b0;
        check_eq("st_clr_acc", 32'(s_acc), 32'd0);
        check_eq("st_clr_ovr", 32'(ovr_o), 32'd0);
        start_i = 1'b1; period_i = 8'd1; p_count_i = 4'd15;
        step(); start_i = 1'b0;
        step();
        check_eq("st_acc_15", 32'(s_acc), 32'd15);
        step();
        check_eq("st_acc_30", 32'(s_acc), 32'd30);
        check_eq("st_sat_30", 32'(s_sat), 32'd0);
        step();
        check_eq("st_acc_31", 32'(s_acc), 32'd31);
        check_eq("st_sat_31", 32'(s_sat), 32'd1);
        step();
        check_eq("st_acc_hold", 32'(s_acc), 32'd31);
        check_eq("wide_acc_60", 32'(acc_o), 32'd60);
        check_eq("wide_sat", 32'(sat_o), 32'd0);
        clear_i = 1'b1; p_count_i = 4'd4;
        step(); clear_i = 1'b0;
        check_eq("st_clr_add", 32'(s_acc), 32'd4);
        check_eq("st_clr_sat", 32'(s_sat), 32'd0);
        stop_i = 1'b1;
        step(); stop_i = 1'b0;
        check_eq("st_acc_end", 32'(s_acc), 32'd8);
        check_eq("st_req_end", 32'(s_req), 32'd0);

        // Mid-operation reset
        start_i = 1'b1; period_i = 8'd1; p_count_i = 4'd9; ready_i = 1'b0;
        step(); start_i = 1'b0;
        step(); step();
        reset = 1'b1;
        step(); reset = 1'b0;
        check_reset_state("mrst");
        step();
        check_eq("mrst_idle", 32'(sw_req_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perf_sampler.md
# perf_sampler

Requester side of the performance-counter readout interface. Pulses `sw_req_o` to a `perf_counters` instance on a programmable period. Captures the `p_count_i` value returned in that same cycle and adds it into a wide saturating accumulator. Presents each captured sample on a valid/ready output for software or a trace buffer. Sits between one `perf_counters` instance and the CSR/trace fabric.

## Interface
- `CNT_W`, 4: width of the attached counter's `p_count_o`.
- `ACC_W`, 16: accumulator width; must be greater than `CNT_W`.
- `PER_W`, 8: width of the sample period field.

- `clk` input 1: clock; all logic is on the rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `start_i` input 1: begin periodic sampling; ignored while not IDLE.
- `stop_i` input 1: end sampling after one flush request.
- `period_i` input PER_W: cycles between requests; latched on `start_i`; a value of 0 is treated as 1.
- `clear_i` input 1: clears `acc_o`, `sat_o` and `ovr_o`.
- `sw_req_o` output 1: read-and-clear request to the counter; driven from registers only.
- `p_count_i` input CNT_W: counter value; valid in the cycle `sw_req_o`=1.
- `sample_o` output CNT_W: last captured sample; held while `valid_o`=1.
- `valid_o` output 1: `sample_o` holds an unconsumed sample.
- `ready_i` input 1: consumer accepts `sample_o` when `valid_o`&`ready_i`.
- `acc_o` output ACC_W: running sum of all captured samples.
- `sat_o` output 1: sticky; the accumulator has saturated.
- `ovr_o` output 1: sticky; an unconsumed sample was overwritten.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN. Reset enters IDLE.
- **IDLE**
  - `sw_req_o`=0.
  - On `start_i`: latch P = max(`period_i`,1), load timer = P-1, go to RUN.
- **RUN**
  - `sw_req_o` = (timer==0).
  - On a request cycle, the timer reloads to P-1; otherwise it decrements by 1.
  - P=1 gives a request every cycle.
- **stop_i while in RUN**
  - If the current cycle is a request cycle, go to IDLE directly; that request is the flush.
  - Otherwise go to DRAIN.
  - `start_i` is ignored while in RUN or DRAIN.
- **DRAIN**
  - `sw_req_o`=1 for exactly one cycle, the capture is performed, then go to IDLE.
  - `stop_i` and `start_i` are ignored in DRAIN.
- **Capture**
  - Performed in every cycle with `sw_req_o`=1.
  - `p_count_i` is zero-extended and added to `acc_o`.
  - `p_count_i` is written into `sample_o`, and `valid_o` is set.
- **Accumulator arithmetic**
  - The sum is computed ACC_W+1 bits wide.
  - If the carry-out is set, `acc_o` = all-ones and `sat_o`=1.
  - Once saturated, `acc_o` stays at all-ones until `clear_i`.
- **clear_i**
  - `acc_o`, `sat_o` and `ovr_o` go to 0.
  - If a capture occurs in the same cycle, `acc_o` = the zero-extended sample, i.e. clear first, then add.
  - `valid_o` and `sample_o` are unaffected.
- **Output handshake**
  - A transfer completes on `valid_o`&`ready_i`; `valid_o` drops in the next cycle unless a new capture occurs.
  - A capture while `valid_o`=1 and `ready_i`=0 overwrites `sample_o` and sets `ovr_o`.
  - A capture in the same cycle as a completed transfer loads the new sample, keeps `valid_o`=1, and does not set `ovr_o`.
- **Overflow of the counter itself**
  - The counter can hold at most 2^CNT_W-1 events between requests.
  - Integrators must bound P so that this limit is never exceeded.
  - The block does not detect counter wrap.

## Timing
- Reset values:
  - state IDLE, timer 0;
  - `sw_req_o`=0, `valid_o`=0, `sample_o`=0;
  - `acc_o`=0, `sat_o`=0, `ovr_o`=0.
- Latencies:
  - The first request occurs P cycles after the `start_i` cycle; for P=1, this is the cycle after `start_i`.
  - `sample_o`, `valid_o`, `acc_o`, `sat_o` and `ovr_o` update in the cycle after the capture cycle.
- DRAIN request: occurs in the cycle after `stop_i`.
- Mid-operation reset: returns all state to reset values on the next edge. The counter's residual events are lost; the counter shares the reset.
- Input path: no combinational path exists from any input to `sw_req_o`.

## Test plan
- **Basic period**
  - Stimulus: `period_i`=3, `start_i` at cycle 0, counter sees 2 events per interval, `ready_i`=1.
  - Response: `sw_req_o` high in cycles 3, 6 and 9; `sample_o`=2 each time; `acc_o` steps 2, 4, 6.
- **Period zero**
  - Stimulus: `period_i`=0, `start_i`, `cpu_trig_i`=1 every cycle.
  - Response: `sw_req_o`=1 every cycle from cycle 1; samples are 1 each cycle; `acc_o` increments by 1 per cycle.
- **Stop and flush**
  - Stimulus: P=5, `stop_i` asserted 2 cycles after a request, 1 event pending.
  - Response: a DRAIN request in the next cycle captures `sample_o`=1, then IDLE. A further `start_i` restarts the period.
- **Stop on a request cycle**
  - Stimulus: `stop_i` asserted in the same cycle as a request.
  - Response: no extra request; IDLE in the next cycle.
- **Overrun**
  - Stimulus: P=2, `ready_i`=0 across two captures of 3 and then 5.
  - Response: `sample_o`=5, `ovr_o`=1.
  - Then `ready_i`=1 in a capture cycle: `valid_o` stays 1, `ovr_o` is unchanged.
- **Saturation and clear**
  - Stimulus: ACC_W=5, repeated samples of 15.
  - Response: `acc_o` goes 15, 30, then 31 with `sat_o`=1.
  - Then `clear_i` coincident with a sample of 4: `acc_o`=4, `sat_o`=0.
